// File: rtl/div_ctrl_pkg.sv
// rtl/div_ctrl_pkg.sv - shared op codes, state encodings and helpers for the divide sequencer
//
// Purpose : ALU control codes recognised as divides, FSM state encoding,
//           and a small op-decode helper used by div_ctrl.
// Ports   : none (package)

package div_ctrl_pkg;

   // ALU control codes for the two divide flavours
   localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
   localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_ZERO = 2'b01,
      DIV_ON   = 2'b10,
      DIV_END  = 2'b11
   } div_state_t;

   function automatic logic is_div_op(input logic [7:0] op);
      return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
   endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Purpose : shift the next dividend bit into the partial remainder and try
//           to subtract the divisor; keep the difference if it is non-negative.
// Ports   : rem      - partial remainder from the previous iteration
//           next_bit - dividend bit shifted in this iteration
//           divisor  - divisor magnitude
//           new_rem  - partial remainder after this iteration
//           q_bit    - quotient bit produced by this iteration

module div_step #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0] rem,
   input  logic              next_bit,
   input  logic [DATA_W-1:0] divisor,
   output logic [DATA_W-1:0] new_rem,
   output logic              q_bit
);

   // Two guard bits: the shifted partial remainder is DATA_W+1 bits wide and
   // the extra MSB carries the borrow of the trial subtraction.
   logic [DATA_W+1:0] trial;
   logic              unused_msb;

   assign trial = {1'b0, rem, next_bit} - {2'b00, divisor};
   assign q_bit = ~trial[DATA_W+1];

   // The partial remainder is always below the divisor, so the top bit of
   // either candidate is zero and can be dropped.
   assign {unused_msb, new_rem} = q_bit ? trial[DATA_W:0] : {rem, next_bit};

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - multi-cycle radix-2 restoring divide sequencer for the E stage
//
// Purpose : decode DIV/DIVU, run DATA_W restoring iterations, stall the front
//           of the pipeline while busy and hold {remainder, quotient} until
//           the E stage advances.
// Ports   : clk, resetn (async, active-low)
//           alucontrolE - E-stage ALU control code
//           srcaE/srcbE - dividend / divisor, latched at start
//           flushE      - annul the E-stage instruction
//           advanceE    - E stage hands its instruction to M
//           div_stall   - hold F/D/E (combinational)
//           div_ready   - result valid
//           hilo_out    - {HI = remainder, LO = quotient}

module div_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic [7:0]            alucontrolE,
   input  logic [DATA_W-1:0]     srcaE,
   input  logic [DATA_W-1:0]     srcbE,
   input  logic                  flushE,
   input  logic                  advanceE,
   output logic                  div_stall,
   output logic                  div_ready,
   output logic [2*DATA_W-1:0]   hilo_out
);

   localparam int CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);

   div_state_t         state;
   logic [CNT_W-1:0]   cnt;
   logic [DATA_W-1:0]  dvd;     // dividend magnitude, shifts out MSB-first while quotient bits shift in
   logic [DATA_W-1:0]  dsr;     // divisor magnitude
   logic [DATA_W-1:0]  rem;     // partial remainder
   logic               neg_q;   // operand signs differ on a signed divide
   logic               neg_r;   // dividend negative on a signed divide

   logic               start;
   logic               op_signed;
   logic               neg_a;
   logic               neg_b;
   logic [DATA_W-1:0]  step_rem;
   logic               step_q;
   logic [DATA_W-1:0]  q_next;
   logic [DATA_W-1:0]  q_fix;
   logic [DATA_W-1:0]  r_fix;

   assign start     = is_div_op(alucontrolE) && !flushE;
   assign op_signed = (alucontrolE == EXE_DIV_OP);
   assign neg_a     = op_signed && srcaE[DATA_W-1];
   assign neg_b     = op_signed && srcbE[DATA_W-1];

   div_step #(.DATA_W(DATA_W)) u_step (
      .rem      (rem),
      .next_bit (dvd[DATA_W-1]),
      .divisor  (dsr),
      .new_rem  (step_rem),
      .q_bit    (step_q)
   );

   assign q_next = {dvd[DATA_W-2:0], step_q};
   assign q_fix  = neg_q ? -q_next   : q_next;
   assign r_fix  = neg_r ? -step_rem : step_rem;

   // Gated by resetn so the stall releases the instant reset is asserted,
   // even if a divide code is still sitting in E.  A flush in a busy state
   // releases the stall in the same cycle.
   assign div_stall = resetn &&
                      (((state == DIV_IDLE) && start) ||
                       (((state == DIV_ZERO) || (state == DIV_ON)) && !flushE));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= DIV_IDLE;
         cnt       <= '0;
         dvd       <= '0;
         dsr       <= '0;
         rem       <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         div_ready <= 1'b0;
         hilo_out  <= '0;
      end else begin
         case (state)
            DIV_IDLE: begin
               div_ready <= 1'b0;
               if (start) begin
                  cnt <= '0;
                  rem <= '0;
                  if (srcbE == '0) begin
                     // keep the raw dividend; it becomes the remainder
                     dvd   <= srcaE;
                     state <= DIV_ZERO;
                  end else begin
                     dvd   <= neg_a ? -srcaE : srcaE;
                     dsr   <= neg_b ? -srcbE : srcbE;
                     neg_q <= neg_a ^ neg_b;
                     neg_r <= neg_a;
                     state <= DIV_ON;
                  end
               end
            end
            DIV_ZERO: begin
               if (flushE) begin
                  state <= DIV_IDLE;
               end else begin
                  hilo_out  <= {dvd, {DATA_W{1'b1}}};
                  div_ready <= 1'b1;
                  state     <= DIV_END;
               end
            end
            DIV_ON: begin
               if (flushE) begin
                  state <= DIV_IDLE;
               end else begin
                  rem <= step_rem;
                  dvd <= q_next;
                  cnt <= cnt + 1'b1;
                  if (cnt == LAST_CNT) begin
                     hilo_out  <= {r_fix, q_fix};
                     div_ready <= 1'b1;
                     state     <= DIV_END;
                  end
               end
            end
            DIV_END: begin
               // start is ignored here: the held instruction must not rerun
               if (advanceE || flushE) begin
                  div_ready <= 1'b0;
                  state     <= DIV_IDLE;
               end
            end
            default: begin
               div_ready <= 1'b0;
               state     <= DIV_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_ctrl.sv
// tb/tb_div_ctrl.sv - directed self-checking bench for div_ctrl

module tb_div_ctrl;
   import div_ctrl_pkg::*;

   localparam int DATA_W = 32;
   localparam logic [7:0] NOP = 8'h00;

   logic                clk;
   logic                resetn;
   logic [7:0]          alucontrolE;
   logic [DATA_W-1:0]   srcaE;
   logic [DATA_W-1:0]   srcbE;
   logic                flushE;
   logic                advanceE;
   logic                div_stall;
   logic                div_ready;
   logic [2*DATA_W-1:0] hilo_out;

   int checks   = 0;
   int failures = 0;

   logic        exp_stall;
   logic        exp_ready;
   logic [63:0] exp_hilo;
   bit          chk_on;

   div_ctrl #(.DATA_W(DATA_W)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .alucontrolE (alucontrolE),
      .srcaE       (srcaE),
      .srcbE       (srcbE),
      .flushE      (flushE),
      .advanceE    (advanceE),
      .div_stall   (div_stall),
      .div_ready   (div_ready),
      .hilo_out    (hilo_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
      end
   endtask

   // Architectural result: remainder takes the dividend's sign, quotient
   // truncates toward zero, divide by zero yields {dividend, all ones}.
   function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return {a, 32'hFFFF_FFFF};
      if (op == EXE_DIVU_OP) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Per-cycle comparison against the expectations maintained by the stimulus.
   always @(negedge clk) begin
      if (chk_on) begin
         check("div_stall", 64'(div_stall), 64'(exp_stall));
         check("div_ready", 64'(div_ready), 64'(exp_ready));
         check("hilo_out",  hilo_out,       exp_hilo);
      end
   end

   task automatic idle(input int n);
      alucontrolE = NOP;
      flushE      = 1'b0;
      advanceE    = 1'b0;
      exp_stall   = 1'b0;
      exp_ready   = 1'b0;
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   // Cycle 0 is the IDLE/start cycle; operands are scrambled afterwards to
   // show they were latched.  The divide op stays in E (stalled) throughout.
   task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit has_lit, input logic [63:0] lit,
                          input int flush_at, input int hold);
      int          lat;
      logic [63:0] m;
      m = model(op, a, b);
      if (has_lit) check("model_vs_literal", m, lit);
      lat = (b == 32'd0) ? 2 : DATA_W + 1;
      alucontrolE = op;
      srcaE       = a;
      srcbE       = b;
      flushE      = 1'b0;
      advanceE    = 1'b0;
      exp_stall   = 1'b1;
      exp_ready   = 1'b0;
      @(posedge clk); #1;
      for (int k = 1; k < lat; k++) begin
         srcaE = $urandom;
         srcbE = $urandom;
         if (k == flush_at) begin
            flushE    = 1'b1;
            exp_stall = 1'b0;
            @(posedge clk); #1;
            flushE      = 1'b0;
            alucontrolE = NOP;
            return;
         end
         @(posedge clk); #1;
      end
      exp_stall = 1'b0;
      exp_ready = 1'b1;
      exp_hilo  = has_lit ? lit : m;
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
      end
      advanceE = 1'b1;
      @(posedge clk); #1;
      advanceE = 1'b0;
   endtask

   initial begin
      resetn      = 1'b0;
      alucontrolE = NOP;
      srcaE       = '0;
      srcbE       = '0;
      flushE      = 1'b0;
      advanceE    = 1'b0;
      exp_stall   = 1'b0;
      exp_ready   = 1'b0;
      exp_hilo    = '0;
      chk_on      = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_stall", 64'(div_stall), 64'd0);
      check("reset_ready", 64'(div_ready), 64'd0);
      check("reset_hilo",  hilo_out,       64'd0);
      chk_on = 1'b1;
      resetn = 1'b1;
      idle(2);

      run_div(EXE_DIVU_OP, 32'd7, 32'd2, 1'b1, 64'h00000001_00000003, -1, 0);
      idle(1);
      run_div(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 1'b1, 64'hFFFFFFFF_FFFFFFFD, -1, 0);
      // back-to-back: next start seen in the IDLE cycle right after advance
      run_div(EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 1'b1, 64'h00000001_FFFFFFFD, -1, 0);
      idle(1);
      run_div(EXE_DIV_OP, 32'd5, 32'd0, 1'b1, 64'h00000005_FFFFFFFF, -1, 0);
      idle(1);
      run_div(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 64'h00000000_80000000, -1, 3);
      idle(1);

      // flush mid-divide: result registers keep the previous value
      run_div(EXE_DIVU_OP, 32'h1234_5678, 32'h10, 1'b0, 64'd0, 10, 0);
      idle(2);
      run_div(EXE_DIVU_OP, 32'd100, 32'd7, 1'b1, 64'h00000002_0000000E, -1, 0);
      idle(1);

      run_div(EXE_DIV_OP,  32'hFFFF_FF9C, 32'd7, 1'b1, 64'hFFFFFFFE_FFFFFFF2, -1, 1);
      idle(1);
      run_div(EXE_DIVU_OP, 32'd3, 32'd10, 1'b1, 64'h00000003_00000000, -1, 0);
      idle(1);
      run_div(EXE_DIV_OP,  32'h8000_0000, 32'd1, 1'b1, 64'h00000000_80000000, -1, 0);
      idle(1);
      run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'h00000000_00000001, -1, 0);
      idle(1);
      run_div(EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1, 1'b0, 64'd0, -1, 0);
      idle(1);
      run_div(EXE_DIVU_OP, 32'hDEAD_BEEF, 32'd0, 1'b0, 64'd0, -1, 2);
      idle(1);

      // asynchronous reset during ON (cycle 15)
      alucontrolE = EXE_DIVU_OP;
      srcaE       = 32'hCAFE_F00D;
      srcbE       = 32'd13;
      exp_stall   = 1'b1;
      exp_ready   = 1'b0;
      @(posedge clk); #1;
      repeat (14) begin
         @(posedge clk); #1;
      end
      #1;
      resetn = 1'b0;
      #1;
      check("async_reset_stall", 64'(div_stall), 64'd0);
      check("async_reset_ready", 64'(div_ready), 64'd0);
      check("async_reset_hilo",  hilo_out,       64'd0);
      exp_stall   = 1'b0;
      exp_ready   = 1'b0;
      exp_hilo    = '0;
      alucontrolE = NOP;
      repeat (2) @(posedge clk);
      #1;
      resetn = 1'b1;
      idle(1);
      run_div(EXE_DIVU_OP, 32'd9, 32'd3, 1'b1, 64'h00000000_00000003, -1, 0);
      idle(2);

      chk_on = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
